// File: rtl/coef_ram_seq_if.sv
// Coefficient RAM sequencer bus bundle.
// Load handshake, sample trigger, SRAM port and coefficient stream.
interface coef_ram_seq_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          iLoadStart;
  logic          iLoadValid;
  logic [DW-1:0] iLoadData;
  logic          oLoadReady;
  logic          iSampleValid;
  logic          oCsnRam;
  logic          oWrnRam;
  logic [AW-1:0] oAddrRam;
  logic [DW-1:0] oWtDtRam;
  logic [DW-1:0] iRdDtRam;
  logic [DW-1:0] oCoef;
  logic          oCoefValid;
  logic [AW-1:0] oCoefIdx;
  logic          oCoefLast;
  logic          oLoadDone;
  logic          oSampleDrop;
  logic          oBusy;

  modport master (
    output iLoadStart, iLoadValid, iLoadData,
    output iSampleValid, iRdDtRam,
    input  oLoadReady, oCsnRam, oWrnRam,
    input  oAddrRam, oWtDtRam, oCoef,
    input  oCoefValid, oCoefIdx, oCoefLast,
    input  oLoadDone, oSampleDrop, oBusy
  );

  modport slave (
    input  iLoadStart, iLoadValid, iLoadData,
    input  iSampleValid, iRdDtRam,
    output oLoadReady, oCsnRam, oWrnRam,
    output oAddrRam, oWtDtRam, oCoef,
    output oCoefValid, oCoefIdx, oCoefLast,
    output oLoadDone, oSampleDrop, oBusy
  );
endinterface

// File: rtl/coef_ram_seq.sv
// FIR coefficient SRAM sequencer: loads DEPTH words,
// then streams them out once per accepted sample request.
module coef_ram_seq #(
  parameter int DEPTH = 10,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic          iClk12M,
  input  logic          iRst,
  coef_ram_seq_if.slave bus
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, READ, FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          loaded_q, loaded_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pidx_q, pidx_d;
  logic [DW-1:0] coef_q, coef_d;
  logic          cval_q, cval_d;
  logic [AW-1:0] cidx_q, cidx_d;
  logic          clast_q, clast_d;

  logic          csn, wrn, lready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  // Next state, SRAM strobes and pulse requests
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    pend_d   = 1'b0;
    pidx_d   = cnt_q;
    csn      = 1'b1;
    wrn      = 1'b1;
    addr     = '0;
    wdata    = '0;
    lready   = 1'b0;
    if (iRst) begin
      state_d  = IDLE;
      cnt_d    = '0;
      loaded_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.iLoadStart) begin
            state_d = LOAD;
            cnt_d   = '0;
            drop_d  = bus.iSampleValid;
          end else if (bus.iSampleValid) begin
            if (loaded_q) begin
              state_d = READ;
              cnt_d   = '0;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        LOAD: begin
          lready = 1'b1;
          drop_d = bus.iSampleValid;
          if (bus.iLoadValid) begin
            csn   = 1'b0;
            wrn   = 1'b0;
            addr  = cnt_q;
            wdata = bus.iLoadData;
            if (cnt_q == LAST) begin
              state_d  = IDLE;
              cnt_d    = '0;
              done_d   = 1'b1;
              loaded_d = 1'b1;
            end else begin
              cnt_d = cnt_q + AW'(1);
            end
          end
        end
        READ: begin
          csn    = 1'b0;
          addr   = cnt_q;
          pend_d = 1'b1;
          drop_d = bus.iSampleValid;
          if (cnt_q == LAST) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        FLUSH: begin
          drop_d  = bus.iSampleValid;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register fed by SRAM read data one cycle after the address
  always_comb begin
    coef_d  = coef_q;
    cidx_d  = cidx_q;
    cval_d  = pend_q;
    clast_d = 1'b0;
    if (pend_q) begin
      coef_d  = bus.iRdDtRam;
      cidx_d  = pidx_q;
      clast_d = (pidx_q == LAST);
    end
  end

  // State and pipeline registers
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      pend_q   <= 1'b0;
      pidx_q   <= '0;
      coef_q   <= '0;
      cval_q   <= 1'b0;
      cidx_q   <= '0;
      clast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      pend_q   <= pend_d;
      pidx_q   <= pidx_d;
      coef_q   <= coef_d;
      cval_q   <= cval_d;
      cidx_q   <= cidx_d;
      clast_q  <= clast_d;
    end
  end

  assign bus.oCsnRam     = csn;
  assign bus.oWrnRam     = wrn;
  assign bus.oAddrRam    = addr;
  assign bus.oWtDtRam    = wdata;
  assign bus.oLoadReady  = lready;
  assign bus.oCoef       = coef_q;
  assign bus.oCoefValid  = cval_q;
  assign bus.oCoefIdx    = cidx_q;
  assign bus.oCoefLast   = clast_q;
  assign bus.oLoadDone   = done_q;
  assign bus.oSampleDrop = drop_q;
  assign bus.oBusy       = (state_q != IDLE);

endmodule

// File: doc/coef_ram_seq.md
COEF_RAM_SEQ -- requirements
Module: coef_ram_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 10, number of FIR coefficients held in the coefficient SRAM.
REQ-002 SHALL have parameter DW, default 16, coefficient data width.
REQ-003 SHALL have parameter AW, default 4, SRAM address width.
REQ-004 iClk12M  input  1  single 12 MHz clock; all state updates on its rising edge.
REQ-005 iRst  input  1  reset, synchronous, active-high.
REQ-006 iLoadStart  input  1  one-cycle pulse; begins a coefficient load of DEPTH words.
REQ-007 iLoadValid  input  1  load word present on iLoadData.
REQ-008 iLoadData  input  DW  coefficient word to write.
REQ-009 oLoadReady  output  1  high when a load word is accepted this cycle.
REQ-010 iSampleValid  input  1  one-cycle pulse; requests one read sweep of all coefficients.
REQ-011 oCsnRam  output  1  SRAM chip select, active-low.
REQ-012 oWrnRam  output  1  SRAM write enable, active-low.
REQ-013 oAddrRam  output  AW  SRAM address.
REQ-014 oWtDtRam  output  DW  SRAM write data.
REQ-015 iRdDtRam  input  DW  SRAM read data, valid one cycle after a read address.
REQ-016 oCoef  output  DW  coefficient to downstream MAC.
REQ-017 oCoefValid  output  1  oCoef/oCoefIdx valid this cycle.
REQ-018 oCoefIdx  output  AW  index of oCoef (0..DEPTH-1).
REQ-019 oCoefLast  output  1  high with oCoefValid when oCoefIdx = DEPTH-1.
REQ-020 oLoadDone  output  1  one-cycle pulse after final load word written.
REQ-021 oSampleDrop  output  1  one-cycle pulse when an iSampleValid is discarded.
REQ-022 oBusy  output  1  high whenever state is not IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, LOAD, READ, FLUSH.
REQ-024 IDLE: oCsnRam=1, oWrnRam=1, oAddrRam=0, oLoadReady=0.
REQ-025 IDLE->LOAD on iLoadStart; IDLE->READ on iSampleValid only when loaded flag set.
REQ-026 iLoadStart and iSampleValid same IDLE cycle: LOAD taken, oSampleDrop pulses next cycle.
REQ-027 iSampleValid in IDLE with loaded flag clear, or in LOAD/READ/FLUSH: ignored, oSampleDrop pulses next cycle.
REQ-028 LOAD: oLoadReady=1; each cycle with iLoadValid=1 drives oCsnRam=0, oWrnRam=0, oAddrRam=word count, oWtDtRam=iLoadData combinationally, count increments.
REQ-029 LOAD with iLoadValid=0: oCsnRam=1, oWrnRam=1, count held (stall, no timeout).
REQ-030 On write of word DEPTH-1: next state IDLE, oLoadDone pulses next cycle, loaded flag set, count wraps to 0.
REQ-031 iLoadStart during LOAD/READ/FLUSH ignored.
REQ-032 READ: oCsnRam=0, oWrnRam=1, oAddrRam steps 0..DEPTH-1, one address per cycle, no gaps.
REQ-033 After address DEPTH-1 issued: READ->FLUSH for one cycle (oCsnRam=1), then IDLE.
REQ-034 oCoef registered from iRdDtRam; oCoefValid, oCoefIdx follow issued read address by 2 cycles (1 SRAM + 1 output register).
REQ-035 Sweep length: iSampleValid at cycle T -> first oCoefValid at T+3, last at T+12, oBusy low from T+12, next sweep accepted from T+12.
REQ-036 oCoefValid SHALL assert exactly DEPTH times per accepted iSampleValid, never during LOAD.
REQ-037 Address counter SHALL never exceed DEPTH-1.

Reset
REQ-038 iRst sampled high SHALL force IDLE next edge regardless of state, abandoning any load or sweep.
REQ-039 Reset values: oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, oCoef=0, oCoefValid=0, oCoefIdx=0, oCoefLast=0, oLoadDone=0, oSampleDrop=0, oBusy=0, loaded flag=0.
REQ-040 Reset mid-LOAD SHALL leave loaded flag 0; partial SRAM contents not invalidated in memory.

Verification
REQ-041 Load 0xA01..0xA0A with iLoadValid continuous -> writes addr 0..9 on 10 consecutive cycles, oLoadDone one pulse.
REQ-042 Load with iLoadValid low every other cycle -> same 10 writes, stalls hold address, no extra writes.
REQ-043 iSampleValid after load -> oCoef 0xA01..0xA0A, oCoefIdx 0..9, oCoefLast only with 0xA0A, first valid 3 cycles after request.
REQ-044 iSampleValid before any load, and again mid-sweep -> no reads, oSampleDrop pulse each time, ongoing sweep unaffected.
REQ-045 iRst at 5th load word, then iSampleValid -> sample dropped; fresh load then sweep returns correct data.
REQ-046 iLoadStart and iSampleValid same cycle -> LOAD entered, oSampleDrop pulse, no oCoefValid.
